// File: rtl/write_back_stage.sv
// -----------------------------------------------------------------------------
// write_back_stage
//
// Final pipeline stage of the MPS core. Picks the result of an operation from
// one of four sources (ALU, data memory, link value, immediate) and turns it
// into a single-cycle register-file write strobe. Loads whose data is not yet
// available at accept time park the stage in WAIT_MEM until the data shows up
// or a bounded timeout expires; a timeout retires the operation with an error
// pulse and no register write.
//
// Optional feature macro: WB_FORWARD_EN
//   defined   -> the fwd_* port mirrors the write port and flags an
//                outstanding load so decode can stall on its destination.
//   undefined -> the fwd_* port exists but is tied to zero.
//
// Reset is synchronous and active-high.
// -----------------------------------------------------------------------------

`ifndef DMEM_DATA_WIDTH
`define DMEM_DATA_WIDTH 8
`endif

module write_back_stage #(
  parameter int DATA_WIDTH     = `DMEM_DATA_WIDTH,
  parameter int REG_ADDR_WIDTH = 3,
  parameter int MEM_TIMEOUT    = 15
) (
  input  logic                      clk,
  input  logic                      rst,

  // operation from the memory-access stage
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [1:0]                in_src_sel,
  input  logic [REG_ADDR_WIDTH-1:0] in_rd,
  input  logic                      in_rd_we,
  input  logic [DATA_WIDTH-1:0]     alu_z,
  input  logic [DATA_WIDTH-1:0]     link,
  input  logic [DATA_WIDTH-1:0]     imm,

  // late load data
  input  logic [DATA_WIDTH-1:0]     mem_value,
  input  logic                      mem_valid,

  // register-file write port
  output logic                      rf_we,
  output logic [REG_ADDR_WIDTH-1:0] rf_addr,
  output logic [DATA_WIDTH-1:0]     rf_data,

  // status
  output logic                      retire,
  output logic                      mem_err,

  // forwarding port towards decode
  output logic                      fwd_valid,
  output logic                      fwd_pending,
  output logic [REG_ADDR_WIDTH-1:0] fwd_addr,
  output logic [DATA_WIDTH-1:0]     fwd_data
);

  // Counter must be able to hold MEM_TIMEOUT itself.
  localparam int CNT_WIDTH = $clog2(MEM_TIMEOUT + 1);

  // The counter is cleared on accept and the first WAIT_MEM cycle sees 0, so
  // the MEM_TIMEOUT-th waiting cycle is the one holding MEM_TIMEOUT-1.
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(MEM_TIMEOUT - 1);
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = CNT_WIDTH'(0);

  localparam logic [1:0] SRC_ALU  = 2'd0;
  localparam logic [1:0] SRC_MEM  = 2'd1;
  localparam logic [1:0] SRC_LINK = 2'd2;
  localparam logic [1:0] SRC_IMM  = 2'd3;

  typedef enum logic {
    ST_IDLE     = 1'b0,
    ST_WAIT_MEM = 1'b1
  } wb_state_e;

  wb_state_e                 state_r;
  logic [CNT_WIDTH-1:0]      cnt_r;
  logic [REG_ADDR_WIDTH-1:0] pend_rd_r;
  logic                      pend_we_r;

  logic [DATA_WIDTH-1:0]     sel_data_s;
  logic                      accept_s;
  logic                      mem_late_s;
  logic                      in_writes_s;
  logic                      pend_writes_s;
  logic                      timeout_s;

  // Register 0 is hard-wired: an operation only writes when it asks to and
  // does not target r0.
  function automatic logic writes_reg(input logic                      we,
                                      input logic [REG_ADDR_WIDTH-1:0] rd);
    return we && (rd != {REG_ADDR_WIDTH{1'b0}});
  endfunction

  // Ready whenever idle; held low while reset is asserted.
  assign in_ready = (state_r == ST_IDLE) && !rst;

  assign accept_s      = in_valid && in_ready;
  assign mem_late_s    = (in_src_sel == SRC_MEM) && !mem_valid;
  assign in_writes_s   = writes_reg(in_rd_we, in_rd);
  assign pend_writes_s = writes_reg(pend_we_r, pend_rd_r);
  assign timeout_s     = (cnt_r == CNT_LAST);

  // Result source selection for operations that complete at accept.
  always_comb begin
    sel_data_s = alu_z;
    case (in_src_sel)
      SRC_ALU:  sel_data_s = alu_z;
      SRC_MEM:  sel_data_s = mem_value;
      SRC_LINK: sel_data_s = link;
      SRC_IMM:  sel_data_s = imm;
      default:  sel_data_s = alu_z;
    endcase
  end

  // Stage FSM: accepts operations, waits for late loads, drives the
  // registered write strobe, retire and error pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= ST_IDLE;
      cnt_r     <= CNT_ZERO;
      pend_rd_r <= {REG_ADDR_WIDTH{1'b0}};
      pend_we_r <= 1'b0;
      rf_we     <= 1'b0;
      rf_addr   <= {REG_ADDR_WIDTH{1'b0}};
      rf_data   <= {DATA_WIDTH{1'b0}};
      retire    <= 1'b0;
      mem_err   <= 1'b0;
    end else begin
      // strobes are single-cycle; address/data hold unless a write happens
      rf_we   <= 1'b0;
      retire  <= 1'b0;
      mem_err <= 1'b0;

      case (state_r)
        ST_IDLE: begin
          if (accept_s) begin
            if (mem_late_s) begin
              // load data not here yet: remember the destination and wait
              pend_rd_r <= in_rd;
              pend_we_r <= in_rd_we;
              cnt_r     <= CNT_ZERO;
              state_r   <= ST_WAIT_MEM;
            end else begin
              retire <= 1'b1;
              if (in_writes_s) begin
                rf_we   <= 1'b1;
                rf_addr <= in_rd;
                rf_data <= sel_data_s;
              end
            end
          end
        end

        ST_WAIT_MEM: begin
          if (mem_valid) begin
            // data wins over a coincident timeout
            retire  <= 1'b1;
            state_r <= ST_IDLE;
            if (pend_writes_s) begin
              rf_we   <= 1'b1;
              rf_addr <= pend_rd_r;
              rf_data <= mem_value;
            end
          end else if (timeout_s) begin
            // give up: retire with error, drop the write
            retire  <= 1'b1;
            mem_err <= 1'b1;
            cnt_r   <= cnt_r + CNT_ONE;
            state_r <= ST_IDLE;
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end

        default: begin
          state_r <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef WB_FORWARD_EN
  logic fwd_pending_s;

  // An outstanding load that will write a real register blocks decode.
  assign fwd_pending_s = (state_r == ST_WAIT_MEM) && pend_writes_s && !rst;

  assign fwd_pending = fwd_pending_s;
  assign fwd_valid   = rf_we;
  assign fwd_addr    = fwd_pending_s ? pend_rd_r : rf_addr;
  assign fwd_data    = rf_data;
`else
  assign fwd_pending = 1'b0;
  assign fwd_valid   = 1'b0;
  assign fwd_addr    = {REG_ADDR_WIDTH{1'b0}};
  assign fwd_data    = {DATA_WIDTH{1'b0}};
`endif

endmodule

// File: tb/tb_write_back_stage.sv
// -----------------------------------------------------------------------------
// tb_write_back_stage
//
// Directed scenarios plus a randomized operation stream for write_back_stage.
// Expected results come from a transaction-level view: each operation either
// completes next cycle, completes one cycle after its late data, or times out
// MEM_TIMEOUT+1 cycles after accept. Forwarding checks follow WB_FORWARD_EN.
// -----------------------------------------------------------------------------

module tb_write_back_stage;

  localparam int DW = 8;
  localparam int AW = 3;
  localparam int T  = 15;

  localparam logic [1:0] S_ALU  = 2'd0;
  localparam logic [1:0] S_MEM  = 2'd1;
  localparam logic [1:0] S_LINK = 2'd2;
  localparam logic [1:0] S_IMM  = 2'd3;

  logic          clk = 1'b0;
  logic          rst;
  logic          in_valid;
  logic          in_ready;
  logic [1:0]    in_src_sel;
  logic [AW-1:0] in_rd;
  logic          in_rd_we;
  logic [DW-1:0] alu_z, link, imm, mem_value;
  logic          mem_valid;
  logic          rf_we;
  logic [AW-1:0] rf_addr;
  logic [DW-1:0] rf_data;
  logic          retire, mem_err;
  logic          fwd_valid, fwd_pending;
  logic [AW-1:0] fwd_addr;
  logic [DW-1:0] fwd_data;

  int vectors     = 0;
  int miscompares = 0;

  // last value written to the register file, which rf_addr/rf_data must hold
  logic [AW-1:0] exp_addr;
  logic [DW-1:0] exp_data;

  write_back_stage #(
    .DATA_WIDTH    (DW),
    .REG_ADDR_WIDTH(AW),
    .MEM_TIMEOUT   (T)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_src_sel (in_src_sel),
    .in_rd      (in_rd),
    .in_rd_we   (in_rd_we),
    .alu_z      (alu_z),
    .link       (link),
    .imm        (imm),
    .mem_value  (mem_value),
    .mem_valid  (mem_valid),
    .rf_we      (rf_we),
    .rf_addr    (rf_addr),
    .rf_data    (rf_data),
    .retire     (retire),
    .mem_err    (mem_err),
    .fwd_valid  (fwd_valid),
    .fwd_pending(fwd_pending),
    .fwd_addr   (fwd_addr),
    .fwd_data   (fwd_data)
  );

  // 10 time-unit clock
  always #5 clk = ~clk;

  // Safety net so the run always terminates.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid   = 1'b0;
    in_src_sel = 2'd0;
    in_rd      = '0;
    in_rd_we   = 1'b0;
    alu_z      = '0;
    link       = '0;
    imm        = '0;
    mem_value  = '0;
    mem_valid  = 1'b0;
  endtask

  // Present one operation; unselected candidates carry random noise.
  task automatic drive_op(input logic [1:0] src, input logic [AW-1:0] rd,
                          input logic we, input logic [DW-1:0] value,
                          input logic mv);
    logic [DW-1:0] cand [4];
    for (int i = 0; i < 4; i++) cand[i] = DW'($urandom);
    cand[src]  = value;
    alu_z      = cand[0];
    mem_value  = cand[1];
    link       = cand[2];
    imm        = cand[3];
    in_valid   = 1'b1;
    in_src_sel = src;
    in_rd      = rd;
    in_rd_we   = we;
    mem_valid  = mv;
  endtask

  function automatic logic will_write(input logic we, input logic [AW-1:0] rd);
    return we && (rd != 0);
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1'b1;
    step();
    step();
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_in_ready: got %b, required 0", in_ready);
    end
    vectors++;
    if ({rf_we, retire, mem_err, rf_addr, rf_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got we=%b ret=%b err=%b addr=%h data=%h, required all 0",
               rf_we, retire, mem_err, rf_addr, rf_data);
    end
    vectors++;
    if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== '0) begin
      miscompares++;
      $display("FAIL reset_fwd: got v=%b p=%b a=%h d=%h, required all 0",
               fwd_valid, fwd_pending, fwd_addr, fwd_data);
    end
    rst = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    #1;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: got %b, required 1", in_ready);
    end
  endtask

  task automatic test_alu();
    drive_op(S_ALU, 3'd3, 1'b1, 8'h5A, 1'b0);
    step();
    clear_inputs();
    exp_addr = 3'd3;
    exp_data = 8'h5A;
    vectors++;
    if ({rf_we, retire, mem_err, rf_addr, rf_data} !== {3'b110, exp_addr, exp_data}) begin
      miscompares++;
      $display("FAIL alu_write: got we=%b ret=%b err=%b addr=%h data=%h, required 1 1 0 3 5a",
               rf_we, retire, mem_err, rf_addr, rf_data);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    srcs [3] = '{S_IMM, S_LINK, S_ALU};
    logic [AW-1:0] rds  [3] = '{3'd1, 3'd2, 3'd0};
    logic [DW-1:0] vals [3] = '{8'h11, 8'h22, 8'h33};
    int            retires = 0;
    for (int i = 0; i < 3; i++) begin
      drive_op(srcs[i], rds[i], 1'b1, vals[i], 1'b0);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL b2b_ready[%0d]: got %b, required 1", i, in_ready);
      end
      step();
      if (rds[i] != 0) begin
        exp_addr = rds[i];
        exp_data = vals[i];
      end
      if (retire === 1'b1) retires++;
      vectors++;
      if ({rf_we, mem_err, rf_addr, rf_data} !== {(rds[i] != 0), 1'b0, exp_addr, exp_data}) begin
        miscompares++;
        $display("FAIL b2b_write[%0d]: got we=%b err=%b addr=%h data=%h, required we=%b 0 %h %h",
                 i, rf_we, mem_err, rf_addr, rf_data, (rds[i] != 0), exp_addr, exp_data);
      end
    end
    clear_inputs();
    step();
    vectors++;
    if (retires != 3 || retire !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_retires: got %0d pulses (trailing %b), required 3 (trailing 0)",
               retires, retire);
    end
  endtask

  task automatic test_mem_late();
    drive_op(S_MEM, 3'd4, 1'b1, 8'h00, 1'b0);
    step();
    clear_inputs();
    for (int k = 1; k <= 3; k++) begin
      vectors++;
      if ({in_ready, rf_we, retire, mem_err} !== 4'b0000) begin
        miscompares++;
        $display("FAIL mem_late_wait[%0d]: got rdy=%b we=%b ret=%b err=%b, required 0 0 0 0",
                 k, in_ready, rf_we, retire, mem_err);
      end
      if (k == 3) begin
        mem_valid = 1'b1;
        mem_value = 8'hC3;
      end
      step();
    end
    clear_inputs();
    exp_addr = 3'd4;
    exp_data = 8'hC3;
    vectors++;
    if ({in_ready, rf_we, retire, mem_err, rf_addr, rf_data} !== {4'b1110, exp_addr, exp_data}) begin
      miscompares++;
      $display("FAIL mem_late_write: got rdy=%b we=%b ret=%b err=%b addr=%h data=%h, required 1 1 1 0 4 c3",
               in_ready, rf_we, retire, mem_err, rf_addr, rf_data);
    end
  endtask

  // race=0: no data ever arrives; race=1: data on the last waiting cycle.
  task automatic test_timeout(input logic race);
    logic [DW-1:0] v;
    v = DW'($urandom);
    drive_op(S_MEM, 3'd6, 1'b1, 8'h00, 1'b0);
    step();
    clear_inputs();
    for (int k = 1; k <= T; k++) begin
      vectors++;
      if ({in_ready, rf_we, retire, mem_err} !== 4'b0000) begin
        miscompares++;
        $display("FAIL timeout_wait[race=%0b,%0d]: got rdy=%b we=%b ret=%b err=%b, required 0 0 0 0",
                 race, k, in_ready, rf_we, retire, mem_err);
      end
      if (race && k == T) begin
        mem_valid = 1'b1;
        mem_value = v;
      end
      step();
    end
    clear_inputs();
    if (race) begin
      exp_addr = 3'd6;
      exp_data = v;
    end
    vectors++;
    if ({in_ready, rf_we, retire, mem_err, rf_addr, rf_data} !==
        {1'b1, race, 1'b1, !race, exp_addr, exp_data}) begin
      miscompares++;
      $display("FAIL timeout_result[race=%0b]: got rdy=%b we=%b ret=%b err=%b addr=%h data=%h, required 1 %b 1 %b %h %h",
               race, in_ready, rf_we, retire, mem_err, rf_addr, rf_data, race, !race, exp_addr, exp_data);
    end
    step();
    vectors++;
    if ({retire, mem_err, rf_we} !== 3'b000) begin
      miscompares++;
      $display("FAIL timeout_pulse_width[race=%0b]: got ret=%b err=%b we=%b, required 0 0 0",
               race, retire, mem_err, rf_we);
    end
  endtask

  task automatic test_reset_in_wait();
    drive_op(S_MEM, 3'd5, 1'b1, 8'h00, 1'b0);
    step();
    clear_inputs();
    step();
    step();
    rst = 1'b1;
    #1;
    vectors++;
    if (in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL rst_wait_ready_low: got %b, required 0", in_ready);
    end
    step();
    rst = 1'b0;
    exp_addr = '0;
    exp_data = '0;
    mem_valid = 1'b1;
    mem_value = 8'h77;
    for (int k = 0; k < T + 3; k++) begin
      step();
      mem_valid = 1'b0;
      vectors++;
      if ({in_ready, rf_we, retire, mem_err, rf_addr, rf_data} !== {4'b1000, exp_addr, exp_data}) begin
        miscompares++;
        $display("FAIL rst_wait_quiet[%0d]: got rdy=%b we=%b ret=%b err=%b addr=%h data=%h, required 1 0 0 0 0 0",
                 k, in_ready, rf_we, retire, mem_err, rf_addr, rf_data);
      end
    end
  endtask

  task automatic test_forward();
    logic [DW-1:0] v;
    v = DW'($urandom);
    drive_op(S_MEM, 3'd5, 1'b1, 8'h00, 1'b0);
    step();
    clear_inputs();
    for (int k = 1; k <= 2; k++) begin
      vectors++;
`ifdef WB_FORWARD_EN
      if ({fwd_pending, fwd_addr, fwd_valid} !== {1'b1, 3'd5, 1'b0}) begin
        miscompares++;
        $display("FAIL fwd_pending[%0d]: got p=%b a=%h v=%b, required 1 5 0",
                 k, fwd_pending, fwd_addr, fwd_valid);
      end
`else
      if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== '0) begin
        miscompares++;
        $display("FAIL fwd_tied_wait[%0d]: got v=%b p=%b a=%h d=%h, required all 0",
                 k, fwd_valid, fwd_pending, fwd_addr, fwd_data);
      end
`endif
      if (k == 2) begin
        mem_valid = 1'b1;
        mem_value = v;
      end
      step();
    end
    clear_inputs();
    exp_addr = 3'd5;
    exp_data = v;
    vectors++;
`ifdef WB_FORWARD_EN
    if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== {2'b10, exp_addr, exp_data}) begin
      miscompares++;
      $display("FAIL fwd_result: got v=%b p=%b a=%h d=%h, required 1 0 %h %h",
               fwd_valid, fwd_pending, fwd_addr, fwd_data, exp_addr, exp_data);
    end
`else
    if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== '0) begin
      miscompares++;
      $display("FAIL fwd_tied_result: got v=%b p=%b a=%h d=%h, required all 0",
               fwd_valid, fwd_pending, fwd_addr, fwd_data);
    end
`endif
  endtask

  // Random stream of operations: immediate results, same-cycle loads, late
  // loads, timeouts and data-on-timeout races, with optional idle gaps that
  // carry stray mem_valid pulses.
  task automatic test_random();
    for (int n = 0; n < 120; n++) begin
      logic [1:0]    src;
      logic [AW-1:0] rd;
      logic          we, mv, err, w;
      logic [DW-1:0] value;
      int            mode, d, k;
      bit            done;
      src   = 2'($urandom_range(0, 3));
      rd    = AW'($urandom);
      we    = ($urandom_range(0, 3) != 0);
      value = DW'($urandom);
      mode  = (src == S_MEM) ? int'($urandom_range(0, 3)) : 0;
      mv    = (src == S_MEM) ? (mode == 0) : 1'($urandom_range(0, 1));
      d     = (mode == 1) ? int'($urandom_range(1, T - 1)) : T;
      drive_op(src, rd, we, value, mv);
      vectors++;
      if (in_ready !== 1'b1) begin
        miscompares++;
        $display("FAIL rnd_ready[%0d]: got %b, required 1", n, in_ready);
      end
      step();
      clear_inputs();
      if (mode != 0) begin
        k    = 1;
        done = 0;
        while (!done) begin
          vectors++;
          if ({in_ready, rf_we, retire, mem_err} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rnd_wait[%0d,%0d]: got rdy=%b we=%b ret=%b err=%b, required 0 0 0 0",
                     n, k, in_ready, rf_we, retire, mem_err);
          end
          if (mode != 2 && k == d) begin
            mem_valid = 1'b1;
            mem_value = value;
            done = 1;
          end else if (k == T) begin
            done = 1;
          end
          step();
          k++;
        end
        mem_valid = 1'b0;
      end
      err = (mode == 2);
      w   = !err && will_write(we, rd);
      if (w) begin
        exp_addr = rd;
        exp_data = value;
      end
      vectors++;
      if ({rf_we, retire, mem_err, rf_addr, rf_data} !== {w, 1'b1, err, exp_addr, exp_data}) begin
        miscompares++;
        $display("FAIL rnd_result[%0d]: src=%0d mode=%0d got we=%b ret=%b err=%b addr=%h data=%h, required %b 1 %b %h %h",
                 n, src, mode, rf_we, retire, mem_err, rf_addr, rf_data, w, err, exp_addr, exp_data);
      end
      vectors++;
`ifdef WB_FORWARD_EN
      if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== {w, 1'b0, exp_addr, exp_data}) begin
        miscompares++;
        $display("FAIL rnd_fwd[%0d]: got v=%b p=%b a=%h d=%h, required %b 0 %h %h",
                 n, fwd_valid, fwd_pending, fwd_addr, fwd_data, w, exp_addr, exp_data);
      end
`else
      if ({fwd_valid, fwd_pending, fwd_addr, fwd_data} !== '0) begin
        miscompares++;
        $display("FAIL rnd_fwd_tied[%0d]: got v=%b p=%b a=%h d=%h, required all 0",
                 n, fwd_valid, fwd_pending, fwd_addr, fwd_data);
      end
`endif
      if ($urandom_range(0, 2) == 0) begin
        mem_valid = 1'($urandom_range(0, 1));
        mem_value = DW'($urandom);
        step();
        mem_valid = 1'b0;
        vectors++;
        if ({in_ready, rf_we, retire, mem_err, rf_addr, rf_data} !== {4'b1000, exp_addr, exp_data}) begin
          miscompares++;
          $display("FAIL rnd_gap[%0d]: got rdy=%b we=%b ret=%b err=%b addr=%h data=%h, required 1 0 0 0 %h %h",
                   n, in_ready, rf_we, retire, mem_err, rf_addr, rf_data, exp_addr, exp_data);
        end
      end
    end
  endtask

  initial begin
    clear_inputs();
    rst = 1'b1;
    test_reset();
    test_alu();
    test_back_to_back();
    test_mem_late();
    test_timeout(1'b0);
    test_timeout(1'b1);
    test_reset_in_wait();
    test_forward();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/write_back_stage.md
# write_back_stage

Registered, parametrised write-back stage for the MPS core. It selects the result from one of four sources: ALU, data memory, link value, or immediate. It waits with a bounded timeout for late memory data, then issues a one-cycle register-file write strobe. It sits between the memory-access stage and the register file, and optionally exposes a forwarding port to decode.

## Interface
Parameters:
- `DATA_WIDTH`, default `` `DMEM_DATA_WIDTH `` (8): width of all data paths.
- `REG_ADDR_WIDTH`, default 3: register-file address width.
- `MEM_TIMEOUT`, default 15: maximum cycles spent in WAIT_MEM; must be ≥1.

Ports (one clock; reset is synchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: synchronous active-high reset.
- `in_valid` in 1: an operation is presented.
- `in_ready` out 1: the stage accepts the operation this cycle.
- `in_src_sel` in 2: result source; 0 ALU, 1 MEM, 2 LINK, 3 IMM.
- `in_rd` in `REG_ADDR_WIDTH`: destination register.
- `in_rd_we` in 1: the operation writes a register.
- `alu_z`, `link`, `imm` in `DATA_WIDTH`: candidate results, sampled at accept.
- `mem_value` in `DATA_WIDTH`: load data, sampled when `mem_valid`=1.
- `mem_valid` in 1: `mem_value` is valid this cycle.
- `rf_we` out 1: register-file write strobe.
- `rf_addr` out `REG_ADDR_WIDTH`: write address.
- `rf_data` out `DATA_WIDTH`: write data.
- `retire` out 1: one-cycle pulse per completed operation, including non-writing and errored ones.
- `mem_err` out 1: one-cycle pulse when a load times out.
- `fwd_valid`, `fwd_pending` out 1; `fwd_addr` out `REG_ADDR_WIDTH`; `fwd_data` out `DATA_WIDTH`: forwarding port.

## Operation
- States: IDLE and WAIT_MEM. `in_ready` = (state == IDLE). An operation is accepted on `in_valid && in_ready`.
- Accept with source ALU, LINK or IMM:
  - The selected value, `in_rd` and the write enable are registered.
  - Next cycle: `rf_we` = `in_rd_we && (in_rd != 0)`, and `retire` = 1.
  - State stays IDLE, so back-to-back accepts give 1 op/cycle.
- Accept with source MEM and `mem_valid`=1 in the same cycle: behaves like the ALU case, using `mem_value`.
- Accept with source MEM and `mem_valid`=0:
  - Latch `in_rd` and `in_rd_we`, clear the timeout counter, go to WAIT_MEM.
  - No strobe is issued next cycle.
- WAIT_MEM:
  - The counter increments each cycle; its width is clog2(`MEM_TIMEOUT`+1).
  - On `mem_valid`: capture `mem_value`, go to IDLE. Next cycle: write strobe (subject to rd≠0 and we) and `retire`.
  - Counter reaches `MEM_TIMEOUT` with no `mem_valid`: go to IDLE. Next cycle: `mem_err`=1 and `retire`=1, `rf_we`=0, and the write is dropped.
- Simultaneous `mem_valid` and timeout in the same cycle: `mem_valid` wins and no error is raised.
- `mem_valid` in IDLE without a matching MEM accept is ignored.
- Writes to register 0 are always suppressed, but `retire` still pulses.
- Data is stored and passed through at full `DATA_WIDTH`, with no extension or truncation.
- `rf_addr` and `rf_data` hold their last values while `rf_we`=0.

## Timing
- Reset values: state IDLE; `in_ready`=0 during reset and 1 from the first cycle after; `rf_we`=0, `rf_addr`=0, `rf_data`=0, `retire`=0, `mem_err`=0; all `fwd_*`=0; counter=0.
- Reset mid-WAIT_MEM: the pending load is dropped with no strobe, no retire and no error. A `mem_valid` arriving later is ignored.
- Latency for ALU, LINK, IMM, or MEM with same-cycle data: accept at cycle N, `rf_we` at N+1.
- Latency for a late load: `mem_valid` at cycle M gives `rf_we` at M+1.
- Timeout: accept at N gives `mem_err` at N+`MEM_TIMEOUT`+1.
- All outputs except `in_ready` and the `fwd_*` signals are registered.

## Configuration
- `WB_FORWARD_EN` defined:
  - `fwd_valid`=`rf_we`; `fwd_addr` and `fwd_data` are copies of `rf_addr` and `rf_data`.
  - `fwd_pending`=1 while in WAIT_MEM with the latched write enable=1 and the latched rd≠0; `fwd_addr` then shows the latched rd so decode can stall.
- `WB_FORWARD_EN` undefined: all `fwd_*` ports are present and tied to 0, and no forwarding logic is built.

## Test plan
- Reset, then accept ALU op with `alu_z`=0x5A, `in_rd`=3 -> next cycle `rf_we`=1, `rf_addr`=3, `rf_data`=0x5A, `retire`=1.
- Three back-to-back ops (IMM 0x11 to r1, LINK 0x22 to r2, ALU 0x33 to r0) -> `in_ready` stays 1; strobes for r1 and r2 only; three `retire` pulses.
- MEM op to r4, `mem_valid` with 0xC3 three cycles later -> `in_ready`=0 for 3 cycles; `rf_we`, r4, 0xC3 one cycle after `mem_valid`.
- MEM op with no `mem_valid` and `MEM_TIMEOUT`=15 -> `mem_err` and `retire` at accept+16, no `rf_we`. Repeat with `mem_valid` on the timeout cycle -> write occurs, no `mem_err`.
- `rst` asserted in WAIT_MEM, then `mem_valid` asserted -> no `rf_we`, `retire` or `mem_err`; `in_ready`=1 after reset.
- With `WB_FORWARD_EN`: pending load to r5 -> `fwd_pending`=1, `fwd_addr`=5. Without it: all `fwd_*` read 0 throughout.
